// File: rtl/add_unit_rr_sched_if.sv
// Request/response bundle for the round-robin add-constant scheduler.
// Handshake: a beat transfers on a rising clk edge where valid && ready; the
// source holds valid and data stable until that edge.
interface add_unit_rr_sched_if #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int WIDTH    = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_data;
  logic [ID_WIDTH-1:0]      res_id;
  logic                     res_carry;
  logic                     busy;
  logic [1:0]               dbg_state;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_carry, busy, dbg_state
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_id, res_carry, busy, dbg_state
  );
endinterface

// File: rtl/add_unit_rr_sched.sv
// Round-robin scheduler sharing one registered "operand + OFFSET" unit
// between NUM_REQ requesters; one transaction in flight at a time.
module add_unit_rr_sched #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int WIDTH    = 8,
  parameter int OFFSET   = 5
) (
  input logic clk,
  input logic rst,
  add_unit_rr_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ID_WIDTH-1:0] r_last_grant;
  logic [ID_WIDTH-1:0] r_id;
  logic [WIDTH-1:0]    r_operand;
  logic [WIDTH-1:0]    r_res_data;
  logic [ID_WIDTH-1:0] r_res_id;
  logic                r_res_carry;

  logic                w_grant_any;
  logic [ID_WIDTH-1:0] w_grant_idx;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic                w_accept;
  logic [WIDTH:0]      w_sum;

  // Walk from the farthest candidate back to the nearest so the first
  // requester after last_grant overwrites any later one.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(r_last_grant) + k) % NUM_REQ]) begin
        w_grant_any = 1'b1;
        w_grant_idx = ID_WIDTH'((int'(r_last_grant) + k) % NUM_REQ);
      end
    end
    w_grant_oh = w_grant_any ? (NUM_REQ'(1) << w_grant_idx) : '0;
  end

  assign w_accept = (r_state == S_IDLE) && w_grant_any;
  assign w_sum    = {1'b0, r_operand} + (WIDTH + 1)'(OFFSET);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_any) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (bus.res_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are forced inactive during reset so a half-finished
  // transaction never leaks a grant or a result.
  always_comb begin
    bus.req_ready = '0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b0;
    if (!rst) begin
      bus.req_ready = (r_state == S_IDLE) ? w_grant_oh : '0;
      bus.res_valid = (r_state == S_RESP);
      bus.busy      = (r_state != S_IDLE);
    end
  end

  assign bus.res_data  = r_res_data;
  assign bus.res_id    = r_res_id;
  assign bus.res_carry = r_res_carry;
  assign bus.dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= ID_WIDTH'(NUM_REQ - 1);
      r_id         <= '0;
      r_operand    <= '0;
      r_res_data   <= '0;
      r_res_id     <= '0;
      r_res_carry  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant_idx;
        r_id         <= w_grant_idx;
        r_operand    <= bus.req_data[int'(w_grant_idx) * WIDTH +: WIDTH];
      end
      if (r_state == S_EXEC) begin
        {r_res_carry, r_res_data} <= w_sum;
        r_res_id                  <= r_id;
      end
    end
  end

endmodule
